// File: rtl/rk_norm_accum.sv
// Sum-of-squares reducer over N consecutive rows of the r_k-old memory (r_old^T * r_old).
// Define RK_NORM_SAT_EN for a saturating accumulator with a sticky overflow flag; otherwise the accumulator wraps.
module rk_norm_accum #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int address_width = 32,
  parameter int acc_width     = 80
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             num_rows,
  output logic [address_width-1:0]             read_address,
  input  logic [element_width*no_of_units-1:0] memory_output,
  output logic                                 busy,
  output logic                                 done,
  output logic [acc_width-1:0]                 result,
  output logic                                 overflow
);

  localparam int LOG_UNITS = $clog2(no_of_units);
  localparam int SQ_W      = 2 * element_width;
  localparam int SUM_W     = SQ_W + LOG_UNITS;
  localparam int ROW_W     = element_width * no_of_units;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] read_address_q, read_address_d;
  logic [address_width-1:0] rows_left_q, rows_left_d;
  logic [1:0]               drain_q, drain_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [acc_width-1:0]     result_q, result_d;
  logic [acc_width-1:0]     acc_q, acc_d;
  logic [acc_width-1:0]     acc_add;

  logic                     s1_valid_q, s1_valid_d;
  logic [ROW_W-1:0]         s1_data_q, s1_data_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [SQ_W-1:0]          s2_sq_q [no_of_units];
  logic [SQ_W-1:0]          s2_sq_d [no_of_units];
  logic signed [SQ_W-1:0]   lane_ext [no_of_units];
  logic                     s3_valid_q, s3_valid_d;
  logic [SUM_W-1:0]         s3_sum_q, s3_sum_d;

  // S1: capture the row only while addresses are being issued
  always_comb begin
    s1_valid_d = (state_q == READ);
    s1_data_d  = (state_q == READ) ? memory_output : s1_data_q;
  end

  // S2: signed square; the most negative lane squares to 2^(2*element_width-2), which still fits
  always_comb begin
    s2_valid_d = s1_valid_q;
    for (int i = 0; i < no_of_units; i++) begin
      lane_ext[i] = SQ_W'($signed(s1_data_q[i*element_width +: element_width]));
      s2_sq_d[i]  = lane_ext[i] * lane_ext[i];
    end
  end

  // S3: balanced binary adder tree, one level per generate iteration
  for (genvar l = 0; l <= LOG_UNITS; l++) begin : g_lvl
    logic [SUM_W-1:0] node [no_of_units >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < no_of_units; i++) begin : g_in
        assign node[i] = SUM_W'(s2_sq_q[i]);
      end
    end else begin : g_add
      for (genvar i = 0; i < (no_of_units >> l); i++) begin : g_sum
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_sum_d   = g_lvl[LOG_UNITS].node[0];
  end

`ifdef RK_NORM_SAT_EN
  localparam int EXT_W = ((acc_width > SUM_W) ? acc_width : SUM_W) + 1;
  logic [EXT_W-1:0] acc_sum;
  logic             acc_sat;
  logic             overflow_q, overflow_d;

  always_comb begin
    acc_sum = EXT_W'(acc_q) + EXT_W'(s3_sum_q);
    acc_sat = |acc_sum[EXT_W-1:acc_width];
    acc_add = acc_sat ? {acc_width{1'b1}} : acc_sum[acc_width-1:0];
  end

  assign overflow = overflow_q;
`else
  logic acc_sat;

  always_comb begin
    acc_sat = 1'b0;
    acc_add = acc_q + acc_width'(s3_sum_q);
  end

  assign overflow = 1'b0;
`endif

  // S4 accumulate plus the sequencing FSM
  always_comb begin
    state_d        = state_q;
    read_address_d = read_address_q;
    rows_left_d    = rows_left_q;
    drain_d        = drain_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    result_d       = result_q;
    acc_d          = s3_valid_q ? acc_add : acc_q;
`ifdef RK_NORM_SAT_EN
    overflow_d     = overflow_q | (s3_valid_q & acc_sat);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          result_d = '0;
`ifdef RK_NORM_SAT_EN
          overflow_d = 1'b0;
`endif
          if (num_rows == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d        = READ;
            busy_d         = 1'b1;
            read_address_d = base_address;
            rows_left_d    = num_rows - address_width'(1);
          end
        end
      end
      READ: begin
        if (rows_left_q == '0) begin
          state_d = DRAIN;
          drain_d = 2'd2;
        end else begin
          read_address_d = read_address_q + address_width'(1);
          rows_left_d    = rows_left_q - address_width'(1);
        end
      end
      DRAIN: begin
        // last row reaches S4 in the final drain cycle, so acc_d is the finished sum
        if (drain_q == 2'd0) begin
          state_d  = DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          result_d = acc_d;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      read_address_q <= '0;
      rows_left_q    <= '0;
      drain_q        <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      acc_q          <= '0;
      s1_valid_q     <= 1'b0;
      s1_data_q      <= '0;
      s2_valid_q     <= 1'b0;
      for (int i = 0; i < no_of_units; i++) s2_sq_q[i] <= '0;
      s3_valid_q     <= 1'b0;
      s3_sum_q       <= '0;
`ifdef RK_NORM_SAT_EN
      overflow_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      read_address_q <= read_address_d;
      rows_left_q    <= rows_left_d;
      drain_q        <= drain_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_q       <= result_d;
      acc_q          <= acc_d;
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s2_valid_q     <= s2_valid_d;
      for (int i = 0; i < no_of_units; i++) s2_sq_q[i] <= s2_sq_d[i];
      s3_valid_q     <= s3_valid_d;
      s3_sum_q       <= s3_sum_d;
`ifdef RK_NORM_SAT_EN
      overflow_q     <= overflow_d;
`endif
    end
  end

  assign read_address = read_address_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;

endmodule

// File: tb/tb_rk_norm_accum.sv
// Self-checking bench for rk_norm_accum (default build: wrapping accumulator, acc_width=80).
// Rows are supplied from a queue; the expected result is the plain arithmetic sum of lane squares.
module tb_rk_norm_accum;

  localparam int EW   = 32;
  localparam int NU   = 8;
  localparam int AW   = 32;
  localparam int ACCW = 80;
  localparam int ROWW = EW * NU;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_address;
  logic [AW-1:0]   num_rows;
  logic [AW-1:0]   read_address;
  logic [ROWW-1:0] memory_output;
  logic            busy;
  logic            done;
  logic [ACCW-1:0] result;
  logic            overflow;

  int errors = 0;
  int checks = 0;

  logic [ROWW-1:0] rows [$];
  logic [AW-1:0]   last_addr;

  rk_norm_accum #(
    .element_width(EW),
    .no_of_units(NU),
    .address_width(AW),
    .acc_width(ACCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_address(base_address),
    .num_rows(num_rows),
    .read_address(read_address),
    .memory_output(memory_output),
    .busy(busy),
    .done(done),
    .result(result),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [ROWW-1:0] fill_row(input logic [EW-1:0] v);
    logic [ROWW-1:0] r;
    for (int l = 0; l < NU; l++) r[l*EW +: EW] = v;
    return r;
  endfunction

  function automatic logic [ROWW-1:0] rand_row();
    logic [ROWW-1:0] r;
    for (int l = 0; l < NU; l++) begin
      case ($urandom_range(0, 7))
        0:       r[l*EW +: EW] = 32'h8000_0000;
        1:       r[l*EW +: EW] = 32'h7FFF_FFFF;
        default: r[l*EW +: EW] = $urandom();
      endcase
    end
    return r;
  endfunction

  // sum over every queued row of sum over lanes of (signed lane)^2, mod 2^ACCW
  function automatic logic [ACCW-1:0] model_sum();
    logic [ACCW-1:0] s;
    longint          v;
    s = '0;
    foreach (rows[r]) begin
      for (int l = 0; l < NU; l++) begin
        v = longint'($signed(rows[r][l*EW +: EW]));
        s = s + ACCW'(v * v);
      end
    end
    return s;
  endfunction

  // Runs one job over the rows in the queue; optionally pokes start mid-run and in the DONE cycle.
  task automatic run_job(input logic [AW-1:0] b, input int n, input bit poke);
    int              done_c;
    logic [ACCW-1:0] exp_res;
    logic [AW-1:0]   exp_addr;
    exp_res  = model_sum();
    done_c   = (n == 0) ? 1 : n + 4;
    exp_addr = last_addr;
    @(negedge clk);
    start         = 1'b1;
    base_address  = b;
    num_rows      = AW'(n);
    memory_output = rand_row();
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      start        = poke && (c == 2 || c == done_c);
      base_address = $urandom();
      num_rows     = AW'($urandom_range(1, 5));
      if (c <= n)     exp_addr = b + AW'(c - 1);
      else if (n > 0) exp_addr = b + AW'(n - 1);
      else            exp_addr = last_addr;
      checks++;
      if (read_address !== exp_addr) begin
        errors++;
        $display("FAIL job_addr cycle=%0d got=%h exp=%h", c, read_address, exp_addr);
      end
      checks++;
      if (done !== (c == done_c)) begin
        errors++;
        $display("FAIL job_done cycle=%0d got=%b exp=%b", c, done, (c == done_c));
      end
      checks++;
      if (busy !== (n > 0 && c < done_c)) begin
        errors++;
        $display("FAIL job_busy cycle=%0d got=%b exp=%b", c, busy, (n > 0 && c < done_c));
      end
      if (c == done_c) begin
        checks++;
        if (result !== exp_res) begin
          errors++;
          $display("FAIL job_result n=%0d got=%h exp=%h", n, result, exp_res);
        end
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL job_overflow got=%b exp=0", overflow);
        end
      end
      memory_output = (c <= n) ? rows[c-1] : rand_row();
    end
    last_addr = exp_addr;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL job_after_idle done=%b busy=%b exp done=0 busy=0", done, busy);
    end
    checks++;
    if (result !== exp_res || read_address !== last_addr) begin
      errors++;
      $display("FAIL job_after_hold result=%h addr=%h exp result=%h addr=%h",
               result, read_address, exp_res, last_addr);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    start         = 1'b0;
    base_address  = '0;
    num_rows      = '0;
    memory_output = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (read_address !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs addr=%h busy=%b done=%b result=%h ovf=%b exp all zero",
               read_address, busy, done, result, overflow);
    end
    rst       = 1'b0;
    last_addr = '0;
  endtask

  task automatic test_single_row();
    logic [ACCW-1:0] want;
    want = 72;
    rows.delete();
    rows.push_back(fill_row(32'd3));
    run_job(32'd5, 1, 1'b0);
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL single_row_72 got=%0d exp=%0d", result, want);
    end
  endtask

  task automatic test_four_rows();
    logic [ACCW-1:0] want;
    want = 240;
    rows.delete();
    for (int k = 0; k < 4; k++) rows.push_back(fill_row(EW'(k + 1)));
    run_job(32'd0, 4, 1'b0);
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL four_rows_240 got=%0d exp=%0d", result, want);
    end
  endtask

  task automatic test_zero_rows();
    rows.delete();
    run_job($urandom(), 0, 1'b0);
  endtask

  task automatic test_most_negative();
    logic [ACCW-1:0] want;
    want = 1;
    want = want << 66;
    rows.delete();
    repeat (2) rows.push_back(fill_row(32'h8000_0000));
    run_job($urandom(), 2, 1'b0);
    checks++;
    if (result !== want) begin
      errors++;
      $display("FAIL most_negative got=%h exp=%h", result, want);
    end
  endtask

  task automatic test_reset_mid_run();
    rows.delete();
    for (int k = 0; k < 10; k++) rows.push_back(rand_row());
    @(negedge clk);
    start        = 1'b1;
    base_address = 32'd100;
    num_rows     = 32'd10;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (read_address !== AW'(100 + c - 1)) begin
        errors++;
        $display("FAIL abort_addr cycle=%0d got=%h exp=%h", c, read_address, AW'(100 + c - 1));
      end
      memory_output = rows[c-1];
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (read_address !== '0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs addr=%h busy=%b done=%b result=%h ovf=%b exp all zero",
               read_address, busy, done, result, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      memory_output = rand_row();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done cycle=%0d done=%b busy=%b exp 0", c, done, busy);
      end
    end
    last_addr = '0;
    rows.delete();
    rows.push_back(rand_row());
    run_job($urandom(), 1, 1'b0);
  endtask

  task automatic test_ignored_start();
    rows.delete();
    for (int k = 0; k < 5; k++) rows.push_back(rand_row());
    run_job(32'd200, 5, 1'b1);
  endtask

  task automatic test_address_wrap();
    rows.delete();
    for (int k = 0; k < 3; k++) rows.push_back(rand_row());
    run_job(32'hFFFF_FFFE, 3, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 12);
      rows.delete();
      for (int k = 0; k < n; k++) rows.push_back(rand_row());
      run_job($urandom(), n, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_four_rows();
    test_zero_rows();
    test_most_negative();
    test_reset_mid_run();
    test_ignored_start();
    test_address_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
